pmp_checker: RTL and testbench
==============================

# pmp_checker

Physical-memory-protection checker in front of the data RAM. Holds `ENTRIES` pmpcfg/pmpaddr CSRs written by the CSR unit. For each data-bus request it produces a registered allow/deny verdict, `pmp_exception_o`, which the RAM consumes one cycle later. It also captures the address of the most recent denied access and keeps a saturating fault counter.

## Interface
- `ENTRIES`, 4: number of PMP regions, 1..4, all packed into pmpcfg0.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low (`RstEnable` = 0).
- `csr_we_i` in 1: CSR write strobe.
- `csr_waddr_i` in 12: CSR write address.
- `csr_wdata_i` in 32: CSR write data.
- `csr_raddr_i` in 12: CSR read address.
- `csr_rdata_o` out 32: combinational read data; 0 for unmapped addresses.
- `chk_req_i` in 1: access to check this cycle.
- `chk_addr_i` in 32: byte address of the access.
- `chk_we_i` in 1: 1 = store, 0 = load.
- `chk_priv_m_i` in 1: 1 = machine mode.
- `chk_valid_o` out 1: verdict valid; exactly one cycle per request.
- `pmp_exception_o` out 1: 1 = access denied; forced 0 when `chk_valid_o` = 0.
- `fault_addr_o` out 32: byte address of the last denied access.
- `fault_cnt_o` out 16: count of denied accesses, saturating.

## Operation
- CSR map:
  - pmpcfg0 at 0x3A0: byte i = cfg of entry i.
  - pmpaddr0..3 at 0x3B0..0x3B3: bits 29:0 = address[31:2]; bits 31:30 read 0.
  - Bytes and entries at or above `ENTRIES` read 0 and ignore writes.
- cfg byte fields:
  - R = bit0, W = bit1, X = bit2 (stored only).
  - A = bits4:3: 00 OFF, 01 TOR, 10 NA4, 11 NAPOT.
  - L = bit7. Bits 6:5 read 0.
- WARL rule: a written combination R=0, W=1 is stored as R=0, W=0.
- Lock rules:
  - A write to cfg byte i is ignored while L(i) = 1; other bytes of the same write still apply.
  - A write to pmpaddr i is ignored if L(i) = 1, or if entry i+1 has L = 1 and A = TOR.
  - L clears only on reset.
- Matching, with `a = chk_addr_i[31:2]` and `p = pmpaddr i`:
  - TOR: `lo <= a < p`, where `lo` = pmpaddr i-1, or 0 for entry 0. If `lo >= p`, no match.
  - NA4: `a == p`.
  - NAPOT: `m = p ^ (p+1)` (30 bit). Match if `(a & ~m) == (p & ~m)`.
  - OFF: never matches.
- Priority: the lowest-numbered matching entry alone decides the verdict.
- Verdict:
  - Matching entry, non-M mode: allow if R (load) or W (store); otherwise deny.
  - Matching entry, M mode: if L = 0, allow; if L = 1, apply the R/W check.
  - No match: M mode allows, non-M denies.
- Fault capture: on a deny, `fault_addr_o <= chk_addr_i` and `fault_cnt_o` increments, holding at 0xFFFF.

## Timing
- Reset (`rst` = 0 at an edge): all cfg, pmpaddr, `chk_valid_o`, `pmp_exception_o`, `fault_addr_o` and `fault_cnt_o` go to 0.
  - A request presented during reset produces no verdict.
  - A verdict pending at reset is dropped.
- Check latency:
  - `chk_req_i` at cycle N gives `chk_valid_o` = 1 and the verdict at N+1, for one cycle.
  - Back-to-back requests give back-to-back verdicts, full throughput, no stall.
- The fault registers update at the same edge as the verdict; visible at N+1.
- CSR write visibility:
  - A write at edge N is visible on `csr_rdata_o` and used by checks from cycle N+1.
  - A check presented in the same cycle as a CSR write uses the pre-write values.
- Address wrap: NAPOT with p = 0x3FFF_FFFF (all ones) matches every address; `p+1` is computed in 30 bits.

## Test plan
- After reset: read 0x3A0 and 0x3B0 -> 0. Non-M load to 0x100 -> deny at N+1, `fault_addr_o` = 0x100, `fault_cnt_o` = 1. M-mode store to 0x100 -> allow.
- TOR region: pmpaddr0 = 0x40, pmpaddr1 = 0x80, cfg1 = 0x0B (TOR, R, W).
  - Non-M store to 0x100 and to 0x1FC -> allow.
  - Non-M store to 0x200 -> deny.
  - Non-M store to 0xFC -> deny.
- NAPOT and priority:
  - pmpaddr0 = 0x1FF (4 KiB at 0x0), cfg0 = 0x19 (NAPOT, R).
  - Non-M load to 0xFFC -> allow; store -> deny.
  - Entry 1 = NA4 at 0x10 with R and W: store to 0x40 still denied, because entry 0 wins.
- Lock:
  - Write cfg0 = 0x99 (L=1, NAPOT, R), then cfg0 = 0x1B -> readback 0x99.
  - Write pmpaddr0 = 0x5 -> ignored.
  - M-mode store to 0x0 -> deny.
  - TOR-lock: cfg1 = 0x89 locks pmpaddr0.
- WARL and same-cycle write: write cfg0 = 0x1A -> reads 0x18. A check in the same cycle as a cfg write that would allow it -> still denied.
- Saturation and reset: 65540 denied checks -> `fault_cnt_o` = 0xFFFF. Assert `rst` with a request pending -> `chk_valid_o` = 0 next cycle, all registers 0.

Source files
------------

// File: rtl/pmp_checker_if.sv
// pmp_checker bus bundle: CSR port plus data-access check port.
// master drives CSR accesses and check requests; slave is the checker.
interface pmp_checker_if;
  logic        csr_we_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        chk_req_i;
  logic [31:0] chk_addr_i;
  logic        chk_we_i;
  logic        chk_priv_m_i;
  logic        chk_valid_o;
  logic        pmp_exception_o;
  logic [31:0] fault_addr_o;
  logic [15:0] fault_cnt_o;

  modport master (
    output csr_we_i, csr_waddr_i, csr_wdata_i, csr_raddr_i,
    output chk_req_i, chk_addr_i, chk_we_i, chk_priv_m_i,
    input  csr_rdata_o, chk_valid_o, pmp_exception_o,
    input  fault_addr_o, fault_cnt_o
  );

  modport slave (
    input  csr_we_i, csr_waddr_i, csr_wdata_i, csr_raddr_i,
    input  chk_req_i, chk_addr_i, chk_we_i, chk_priv_m_i,
    output csr_rdata_o, chk_valid_o, pmp_exception_o,
    output fault_addr_o, fault_cnt_o
  );
endinterface

// File: rtl/pmp_checker.sv
// PMP checker: pmpcfg0/pmpaddr CSRs, registered allow/deny verdict,
// last-fault address capture and saturating fault counter.
module pmp_checker #(
  parameter int ENTRIES = 4
) (
  input logic       clk,
  input logic       rst,
  pmp_checker_if.slave bus
);

  localparam logic [11:0] CfgAddr  = 12'h3A0;
  localparam logic [11:0] AddrBase = 12'h3B0;

  localparam logic [1:0] A_OFF   = 2'b00;
  localparam logic [1:0] A_TOR   = 2'b01;
  localparam logic [1:0] A_NA4   = 2'b10;
  localparam logic [1:0] A_NAPOT = 2'b11;

  logic [7:0]  cfg_q   [4];
  logic [7:0]  cfg_d   [4];
  logic [29:0] paddr_q [4];
  logic [29:0] paddr_d [4];

  logic [3:0]  addr_lock;
  logic [29:0] lo      [4];
  logic [29:0] nmask   [4];
  logic [3:0]  hit;
  logic [29:0] a;
  logic        allow;

  logic        valid_q;
  logic        exc_q;
  logic [31:0] fault_addr_q;
  logic [15:0] fault_cnt_q;

  logic        unused_wdata;

  assign unused_wdata = ^bus.csr_wdata_i[31:30];
  assign a = bus.chk_addr_i[31:2];

  // R=0,W=1 collapses to R=0,W=0; bits 6:5 are hardwired zero
  function automatic logic [7:0] cfg_warl(input logic [7:0] w);
    return {w[7], 2'b00, w[4:3], w[2], w[1] & w[0], w[0]};
  endfunction

  // pmpaddr i is frozen by its own lock or by a locked TOR entry above it
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      addr_lock[i] = cfg_q[i][7] |
                     (cfg_q[i+1][7] & (cfg_q[i+1][4:3] == A_TOR));
    end
    addr_lock[3] = cfg_q[3][7];
  end

  // CSR write path; entries at or above ENTRIES never change from zero
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cfg_d[i]   = cfg_q[i];
      paddr_d[i] = paddr_q[i];
    end
    if (bus.csr_we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (i < ENTRIES) begin
          if (bus.csr_waddr_i == CfgAddr && !cfg_q[i][7])
            cfg_d[i] = cfg_warl(bus.csr_wdata_i[8*i +: 8]);
          if (bus.csr_waddr_i == AddrBase + 12'(i) && !addr_lock[i])
            paddr_d[i] = bus.csr_wdata_i[29:0];
        end
      end
    end
  end

  // CSR read mux, zero for unmapped addresses
  always_comb begin
    bus.csr_rdata_o = '0;
    if (bus.csr_raddr_i == CfgAddr)
      bus.csr_rdata_o = {cfg_q[3], cfg_q[2], cfg_q[1], cfg_q[0]};
    for (int i = 0; i < 4; i++) begin
      if (bus.csr_raddr_i == AddrBase + 12'(i))
        bus.csr_rdata_o = {2'b00, paddr_q[i]};
    end
  end

  // per-entry region match; TOR base is the previous pmpaddr
  always_comb begin
    lo[0] = '0;
    for (int i = 1; i < 4; i++) begin
      lo[i] = paddr_q[i-1];
    end
    for (int i = 0; i < 4; i++) begin
      nmask[i] = ~(paddr_q[i] ^ (paddr_q[i] + 30'd1));
      unique case (cfg_q[i][4:3])
        A_TOR:   hit[i] = (a >= lo[i]) && (a < paddr_q[i]);
        A_NA4:   hit[i] = (a == paddr_q[i]);
        A_NAPOT: hit[i] = ((a & nmask[i]) == (paddr_q[i] & nmask[i]));
        A_OFF:   hit[i] = 1'b0;
        default: hit[i] = 1'b0;
      endcase
    end
  end

  // lowest-numbered hit decides; scan high to low so it lands last
  always_comb begin
    allow = bus.chk_priv_m_i;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) begin
        allow = (bus.chk_priv_m_i && !cfg_q[i][7]) ||
                (bus.chk_we_i ? cfg_q[i][1] : cfg_q[i][0]);
      end
    end
  end

  // CSR state, verdict and fault capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        cfg_q[i]   <= '0;
        paddr_q[i] <= '0;
      end
      valid_q      <= 1'b0;
      exc_q        <= 1'b0;
      fault_addr_q <= '0;
      fault_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cfg_q[i]   <= cfg_d[i];
        paddr_q[i] <= paddr_d[i];
      end
      valid_q <= bus.chk_req_i;
      exc_q   <= bus.chk_req_i & ~allow;
      if (bus.chk_req_i && !allow) begin
        fault_addr_q <= bus.chk_addr_i;
        if (fault_cnt_q != 16'hFFFF)
          fault_cnt_q <= fault_cnt_q + 16'd1;
      end
    end
  end

  assign bus.chk_valid_o     = valid_q;
  assign bus.pmp_exception_o = valid_q & exc_q;
  assign bus.fault_addr_o    = fault_addr_q;
  assign bus.fault_cnt_o     = fault_cnt_q;

endmodule

// File: tb/tb_pmp_checker.sv
// pmp_checker bench: directed stimulus, expected verdicts
// queued at drive time and popped when chk_valid_o fires.
module tb_pmp_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pmp_checker_if bus ();

  pmp_checker #(.ENTRIES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        deny;
    logic [31:0] fa;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] m_fa  = '0;
  logic [15:0] m_cnt = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic pend;
    exp_t e;
    pend = bus.chk_req_i && rst;
    @(posedge clk);
    #1;
    check("valid", 32'(bus.chk_valid_o), 32'(pend));
    if (bus.chk_valid_o) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("deny", 32'(bus.pmp_exception_o), 32'(e.deny));
        check("fault_addr", bus.fault_addr_o, e.fa);
        check("fault_cnt", 32'(bus.fault_cnt_o), 32'(e.cnt));
      end
    end else begin
      check("exc_idle", 32'(bus.pmp_exception_o), 32'd0);
      sb.delete();
    end
  endtask

  task automatic do_req(input logic [31:0] addr, input logic we,
                        input logic m, input logic deny);
    bus.chk_req_i    = 1'b1;
    bus.chk_addr_i   = addr;
    bus.chk_we_i     = we;
    bus.chk_priv_m_i = m;
    if (deny) begin
      m_fa = addr;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    sb.push_back('{deny, m_fa, m_cnt});
    tick();
    bus.chk_req_i = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] ad, input logic [31:0] d);
    bus.csr_we_i    = 1'b1;
    bus.csr_waddr_i = ad;
    bus.csr_wdata_i = d;
    tick();
    bus.csr_we_i = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] ad,
                        input logic [31:0] exp);
    bus.csr_raddr_i = ad;
    #1;
    check(tag, bus.csr_rdata_o, exp);
  endtask

  task automatic check_zero_state();
    check("rst_exc", 32'(bus.pmp_exception_o), 32'd0);
    check("rst_fa", bus.fault_addr_o, 32'd0);
    check("rst_cnt", 32'(bus.fault_cnt_o), 32'd0);
    csr_rd("rst_cfg", 12'h3A0, 32'd0);
    for (int i = 0; i < 4; i++)
      csr_rd("rst_addr", 12'h3B0 + 12'(i), 32'd0);
  endtask

  initial begin
    bus.csr_we_i     = 1'b0;
    bus.csr_waddr_i  = '0;
    bus.csr_wdata_i  = '0;
    bus.csr_raddr_i  = '0;
    bus.chk_req_i    = 1'b0;
    bus.chk_addr_i   = '0;
    bus.chk_we_i     = 1'b0;
    bus.chk_priv_m_i = 1'b0;

    tick();
    tick();
    rst = 1'b1;
    check_zero_state();
    csr_rd("unmapped_3b4", 12'h3B4, 32'd0);
    csr_rd("unmapped_123", 12'h123, 32'd0);

    do_req(32'h100, 1'b0, 1'b0, 1'b1);
    do_req(32'h100, 1'b1, 1'b1, 1'b0);

    csr_wr(12'h3B0, 32'h40);
    csr_wr(12'h3B1, 32'h80);
    csr_wr(12'h3A0, 32'h0000_0B00);
    csr_rd("tor_cfg", 12'h3A0, 32'h0000_0B00);
    do_req(32'h100, 1'b1, 1'b0, 1'b0);
    do_req(32'h1FC, 1'b1, 1'b0, 1'b0);
    do_req(32'h200, 1'b1, 1'b0, 1'b1);
    do_req(32'h0FC, 1'b1, 1'b0, 1'b1);

    csr_wr(12'h3B0, 32'h1FF);
    csr_wr(12'h3A0, 32'h0000_0019);
    do_req(32'hFFC, 1'b0, 1'b0, 1'b0);
    do_req(32'hFFC, 1'b1, 1'b0, 1'b1);
    csr_wr(12'h3B1, 32'h10);
    csr_rd("na4_addr", 12'h3B1, 32'h10);
    csr_wr(12'h3A0, 32'h0000_1319);
    do_req(32'h40, 1'b1, 1'b0, 1'b1);
    do_req(32'h40, 1'b0, 1'b0, 1'b0);

    csr_wr(12'h3A0, 32'h0000_1399);
    csr_wr(12'h3A0, 32'h0000_031B);
    csr_rd("lock_cfg", 12'h3A0, 32'h0000_0399);
    csr_wr(12'h3B0, 32'h5);
    csr_rd("lock_addr", 12'h3B0, 32'h1FF);
    do_req(32'h0, 1'b1, 1'b1, 1'b1);
    do_req(32'h0, 1'b0, 1'b1, 1'b0);

    bus.chk_req_i  = 1'b1;
    bus.chk_addr_i = 32'h8000_0000;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.chk_req_i = 1'b0;
    m_fa  = '0;
    m_cnt = '0;
    check_zero_state();
    tick();

    csr_wr(12'h3A0, 32'h0000_8900);
    csr_wr(12'h3B0, 32'h7);
    csr_rd("torlock_addr", 12'h3B0, 32'h0);
    csr_wr(12'h3A0, 32'h0000_001A);
    csr_rd("warl_cfg", 12'h3A0, 32'h0000_8918);

    do_req(32'h0, 1'b0, 1'b0, 1'b1);
    bus.csr_we_i    = 1'b1;
    bus.csr_waddr_i = 12'h3A0;
    bus.csr_wdata_i = 32'h0000_0019;
    do_req(32'h0, 1'b0, 1'b0, 1'b1);
    bus.csr_we_i = 1'b0;
    do_req(32'h0, 1'b0, 1'b0, 1'b0);

    csr_wr(12'h3B2, 32'hFFFF_FFFF);
    csr_rd("addr_hi_zero", 12'h3B2, 32'h3FFF_FFFF);
    csr_wr(12'h3A0, 32'h0019_0019);
    do_req(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    do_req(32'h1234_5678, 1'b0, 1'b0, 1'b0);
    do_req(32'h1234_5678, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 65540; i++)
      do_req(32'h8000_0000 + 32'(i << 2), 1'b1, 1'b0, 1'b1);
    check("saturated", 32'(bus.fault_cnt_o), 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
